// File: rtl/instruction_decode_pipe_if.sv
// Decode-stage bus: IF/ID instruction, write-back port, EX hazard info and ID/EX outputs.
// Master drives the instruction/write-back side; slave is the decode stage.
interface instruction_decode_pipe_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REGS   = 32
);
    localparam int unsigned ADDR_W = $clog2(NUM_REGS);

    logic [31:0]            Instruction;
    logic                   InstrValid;
    logic                   WB_RegWrite;
    logic [ADDR_W-1:0]      WB_rDest;
    logic [DATA_WIDTH-1:0]  WB_Data;
    logic                   EX_MemRead;
    logic [ADDR_W-1:0]      EX_rDest;
    logic                   Flush;
    logic                   Stall;
    logic                   EX_Valid;
    logic                   RegDst;
    logic                   ALUSrc;
    logic                   MemRead;
    logic                   MemWrite;
    logic                   MemToReg;
    logic                   RegWriteOut;
    logic                   Branch;
    logic [3:0]             ALUOp;
    logic [DATA_WIDTH-1:0]  Reg_Data1;
    logic [DATA_WIDTH-1:0]  Reg_Data2;
    logic [DATA_WIDTH-1:0]  ImmExt;
    logic [ADDR_W-1:0]      Rs;
    logic [ADDR_W-1:0]      Rt;
    logic [ADDR_W-1:0]      Rd;

    modport master (
        output Instruction, InstrValid, WB_RegWrite, WB_rDest, WB_Data,
               EX_MemRead, EX_rDest, Flush,
        input  Stall, EX_Valid, RegDst, ALUSrc, MemRead, MemWrite, MemToReg,
               RegWriteOut, Branch, ALUOp, Reg_Data1, Reg_Data2, ImmExt, Rs, Rt, Rd
    );

    modport slave (
        input  Instruction, InstrValid, WB_RegWrite, WB_rDest, WB_Data,
               EX_MemRead, EX_rDest, Flush,
        output Stall, EX_Valid, RegDst, ALUSrc, MemRead, MemWrite, MemToReg,
               RegWriteOut, Branch, ALUOp, Reg_Data1, Reg_Data2, ImmExt, Rs, Rt, Rd
    );
endinterface

// File: rtl/instruction_decode_pipe.sv
// MIPS-subset decode stage: register file, load-use stall, registered ID/EX boundary.
// Optional macro DECODE_BYPASS_EN: same-cycle write-back forwarding into the operands.
module instruction_decode_pipe #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REGS   = 32
) (
    input  logic                      Clock,
    input  logic                      Reset,
    instruction_decode_pipe_if.slave  bus
);
    localparam int unsigned ADDR_W = $clog2(NUM_REGS);

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_SLT = 4'd4;
    localparam logic [3:0] ALU_MUL = 4'd5;

    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       branch;
        logic [3:0] alu_op;
    } ctrl_t;

    logic [DATA_WIDTH-1:0] rf_q [NUM_REGS];

    logic [5:0]            opcode;
    logic [5:0]            funct;
    logic [ADDR_W-1:0]     rs;
    logic [ADDR_W-1:0]     rt;
    logic [ADDR_W-1:0]     rd;
    logic [DATA_WIDTH-1:0] imm_ext;
    logic [DATA_WIDTH-1:0] rd_data1;
    logic [DATA_WIDTH-1:0] rd_data2;

    ctrl_t                 ctrl_dec;
    logic                  legal;
    logic                  rt_read;
    logic                  r_type;
    logic [3:0]            r_alu;
    logic                  stall;
    logic                  wb_we;

    ctrl_t                 ctrl_d,  ctrl_q;
    logic                  valid_d, valid_q;
    logic [DATA_WIDTH-1:0] data1_d, data1_q;
    logic [DATA_WIDTH-1:0] data2_d, data2_q;
    logic [DATA_WIDTH-1:0] imm_d,   imm_q;
    logic [ADDR_W-1:0]     rs_d,    rs_q;
    logic [ADDR_W-1:0]     rt_d,    rt_q;
    logic [ADDR_W-1:0]     rd_d,    rd_q;

    // Instruction field extraction; register fields keep only the low ADDR_W bits.
    assign opcode  = bus.Instruction[31:26];
    assign funct   = bus.Instruction[5:0];
    assign rs      = bus.Instruction[21 +: ADDR_W];
    assign rt      = bus.Instruction[16 +: ADDR_W];
    assign rd      = bus.Instruction[11 +: ADDR_W];
    assign imm_ext = DATA_WIDTH'($signed(bus.Instruction[15:0]));
    assign wb_we   = bus.WB_RegWrite && (bus.WB_rDest != '0);

    // Asynchronous register-file read; r0 is hardwired to zero.
    always_comb begin
        rd_data1 = (rs == '0) ? '0 : rf_q[rs];
        rd_data2 = (rt == '0) ? '0 : rf_q[rt];
`ifdef DECODE_BYPASS_EN
        if (wb_we && (bus.WB_rDest == rs)) rd_data1 = bus.WB_Data;
        if (wb_we && (bus.WB_rDest == rt)) rd_data2 = bus.WB_Data;
`endif
    end

    // Opcode/funct decode into control bundle, legality and rt usage.
    always_comb begin
        ctrl_dec = '0;
        legal    = 1'b0;
        rt_read  = 1'b0;
        r_type   = 1'b0;
        r_alu    = ALU_ADD;
        case (opcode)
            6'h00: begin
                r_type = 1'b1;
                case (funct)
                    6'h20:   r_alu = ALU_ADD;
                    6'h22:   r_alu = ALU_SUB;
                    6'h24:   r_alu = ALU_AND;
                    6'h25:   r_alu = ALU_OR;
                    6'h2A:   r_alu = ALU_SLT;
                    default: r_type = 1'b0;
                endcase
            end
            6'h1C: begin
                if (funct == 6'h02) begin
                    r_type = 1'b1;
                    r_alu  = ALU_MUL;
                end
            end
            6'h08: begin
                legal              = 1'b1;
                ctrl_dec.alu_src   = 1'b1;
                ctrl_dec.reg_write = 1'b1;
                ctrl_dec.alu_op    = ALU_ADD;
            end
            6'h23: begin
                legal               = 1'b1;
                ctrl_dec.alu_src    = 1'b1;
                ctrl_dec.mem_read   = 1'b1;
                ctrl_dec.mem_to_reg = 1'b1;
                ctrl_dec.reg_write  = 1'b1;
                ctrl_dec.alu_op     = ALU_ADD;
            end
            6'h2B: begin
                legal              = 1'b1;
                rt_read            = 1'b1;
                ctrl_dec.alu_src   = 1'b1;
                ctrl_dec.mem_write = 1'b1;
                ctrl_dec.alu_op    = ALU_ADD;
            end
            6'h04: begin
                legal           = 1'b1;
                rt_read         = 1'b1;
                ctrl_dec.branch = 1'b1;
                ctrl_dec.alu_op = ALU_SUB;
            end
            default: ;
        endcase
        if (r_type) begin
            legal              = 1'b1;
            rt_read            = 1'b1;
            ctrl_dec.reg_dst   = 1'b1;
            ctrl_dec.reg_write = 1'b1;
            ctrl_dec.alu_op    = r_alu;
        end
    end

    // Load-use hazard: the load in EX targets a register this instruction reads.
    assign stall = bus.InstrValid && !bus.Flush && bus.EX_MemRead && (bus.EX_rDest != '0)
                   && ((bus.EX_rDest == rs) || ((bus.EX_rDest == rt) && rt_read));

    // ID/EX next state: flush or stall inject a bubble; operands and fields always load.
    always_comb begin
        ctrl_d  = '0;
        valid_d = 1'b0;
        data1_d = rd_data1;
        data2_d = rd_data2;
        imm_d   = imm_ext;
        rs_d    = rs;
        rt_d    = rt;
        rd_d    = rd;
        if (!bus.Flush && !stall && bus.InstrValid && legal) begin
            ctrl_d  = ctrl_dec;
            valid_d = 1'b1;
        end
    end

    // ID/EX register and register-file write port; write-back ignores stall and flush.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            ctrl_q  <= '0;
            valid_q <= 1'b0;
            data1_q <= '0;
            data2_q <= '0;
            imm_q   <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
            for (int i = 0; i < int'(NUM_REGS); i++) rf_q[i] <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            valid_q <= valid_d;
            data1_q <= data1_d;
            data2_q <= data2_d;
            imm_q   <= imm_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            rd_q    <= rd_d;
            if (wb_we) rf_q[bus.WB_rDest] <= bus.WB_Data;
        end
    end

    assign bus.Stall       = stall;
    assign bus.EX_Valid    = valid_q;
    assign bus.RegDst      = ctrl_q.reg_dst;
    assign bus.ALUSrc      = ctrl_q.alu_src;
    assign bus.MemRead     = ctrl_q.mem_read;
    assign bus.MemWrite    = ctrl_q.mem_write;
    assign bus.MemToReg    = ctrl_q.mem_to_reg;
    assign bus.RegWriteOut = ctrl_q.reg_write;
    assign bus.Branch      = ctrl_q.branch;
    assign bus.ALUOp       = ctrl_q.alu_op;
    assign bus.Reg_Data1   = data1_q;
    assign bus.Reg_Data2   = data2_q;
    assign bus.ImmExt      = imm_q;
    assign bus.Rs          = rs_q;
    assign bus.Rt          = rt_q;
    assign bus.Rd          = rd_q;
endmodule
